dram_frame_scheduler: RTL and testbench
=======================================

// Module: dram_frame_scheduler
// PURPOSE
//  Frame-buffer manager for the DRAM write path. Owns NBUF frame buffers at cfg_base_addr + i*cfg_stride.
//  Hands the DRAM writer a free buffer per frame and tracks its completion. Gives one reader the newest complete frame.
//  Never lets the writer touch a buffer the reader holds. Sits between PS config regs, DramWriter and the reader DMA.
// PARAMETERS
//  NBUF     3    number of frame buffers, 2..8
//  ADDR_W   32   byte-address width
// PORTS
//  fclk             in   1       sole clock
//  rst              in   1       synchronous, active-high reset
//  cfg_enable       in   1       1 = schedule frames; 0 = finish current frame, then idle
//  cfg_base_addr    in   ADDR_W  address of buffer 0
//  cfg_stride       in   ADDR_W  byte distance between buffers
//  cfg_frame_bytes  in   32      bytes per frame, multiple of 128, nonzero
//  wr_frame_valid   out  1       frame command to writer
//  wr_frame_ready   in   1       writer accepts command
//  wr_BUF_ADDR      out  ADDR_W  buffer start for writer
//  wr_FRAME_BYTES   out  32      frame size for writer
//  wr_frame_done    in   1       1-cycle pulse: writer issued last burst of frame
//  rd_frame_valid   out  1       newest complete frame available
//  rd_frame_ready   in   1       reader claims it
//  rd_BUF_ADDR      out  ADDR_W  address of offered frame
//  rd_frame_done    in   1       1-cycle pulse: reader releases claimed buffer
//  frames_written   out  32      completed writes, wraps
//  frames_dropped   out  32      complete frames discarded unread, wraps
//  cfg_error        out  1       sticky; cfg_frame_bytes invalid at issue time
// BEHAVIOUR
//  Per-buffer state: FREE, WRITING, FULL, READING. At most one buffer is in each of WRITING, FULL and READING.
//  Reset: all buffers FREE, wfsm=W_IDLE. wr_frame_valid=0, rd_frame_valid=0, addrs=0, counters=0, cfg_error=0.
//  Writer FSM:
//  - W_IDLE -> W_ISSUE when cfg_enable and some buffer is FREE and cfg is valid.
//    - Pick: first FREE index at or after (last_written+1) mod NBUF; round-robin.
//    - Mark WRITING. Register wr_BUF_ADDR = base + idx*stride (mod 2^ADDR_W) and wr_FRAME_BYTES.
//  - W_ISSUE: wr_frame_valid=1, outputs stable until wr_frame_ready; then -> W_BUSY.
//  - W_BUSY: on wr_frame_done -> W_IDLE. WRITING buffer becomes FULL; frames_written++.
//    - Any previously FULL buffer becomes FREE; frames_dropped++.
//  Invalid cfg: cfg_frame_bytes[6:0]!=0 or ==0 when the W_IDLE issue check passes -> cfg_error=1, stay W_IDLE.
//  Earliest reissue: the cycle after wr_frame_done, W_IDLE evaluates; wr_frame_valid rises the following cycle (2-cycle gap).
//  Reader:
//  - rd_frame_valid = FULL buffer exists and no buffer READING; rd_BUF_ADDR = its address. Both registered.
//  - rd_frame_valid & rd_frame_ready: FULL -> READING; rd_frame_valid drops next cycle.
//  - rd_frame_done: READING -> FREE. rd_frame_done with nothing READING is ignored.
//  Simultaneous events, decided on pre-edge state:
//  - rd claim + wr_frame_done: reader gets the old FULL, new frame becomes FULL, no drop.
//  - rd_frame_done + W_IDLE pick: released buffer is not pickable until the next cycle.
//  NBUF=2 with one FULL and one READING: writer stalls in W_IDLE, no drop.
//  cfg_enable=0 mid-frame: W_ISSUE/W_BUSY run to completion; no new issue.
//  cfg_* changes mid-frame affect only the next issue.
//  rst mid-frame: everything returns to reset state next cycle. Writer must be reset concurrently; in-flight bursts are abandoned.
// STRUCTURE
//  Package dram_sched_pkg: typedef enum buf_state_t {FREE,WRITING,FULL,READING}; localparam BURST_BYTES=128.
//  Sub-module rr_free_picker: combinational round-robin first-FREE search over NBUF state vector.
//  - Inputs: state vector, start index. Outputs: found, idx.
//  Top: writer FSM, reader claim logic, address multiply-add, counters.
// TESTING
//  1 base=0x1000_0000, stride=0x10_0000, bytes=0x4_B000, enable. Writer accepts immediately.
//    -> wr_BUF_ADDR 0x1000_0000, then 0x1010_0000, 0x1020_0000, wrap to 0x1000_0000.
//  2 No reader; 5 wr_frame_done pulses -> frames_written=5, frames_dropped=4, rd_frame_valid=1, rd_BUF_ADDR=buffer of frame 5.
//  3 Reader claims buf0 and holds it through 6 frames (NBUF=3) -> wr_BUF_ADDR never 0x1000_0000 while held.
//    rd_frame_done -> buf0 reused.
//  4 NBUF=2, reader holds one buffer and one FULL -> wr_frame_valid stays 0. rd_frame_done -> issue resumes within 2 cycles.
//  5 Same-cycle rd claim and wr_frame_done -> reader gets older address, frames_dropped unchanged.
//    bytes=0x4_B010 -> cfg_error=1, no issue.
//  6 rst pulse while W_BUSY and READING -> all outputs at reset values next cycle.
//    Re-enable -> first issue at buffer 0.

Source files
------------

// File: rtl/dram_frame_scheduler_pkg.sv
// Shared types and constants for the DRAM frame-buffer scheduler.
//   buf_state_t : lifecycle of one frame buffer
//   w_state_t   : writer command FSM state (also exported for debug)
//   frame_bytes_ok() : frame size must be a nonzero multiple of one burst
package dram_sched_pkg;

    localparam int BURST_BYTES = 128;
    localparam int BURST_LSB   = $clog2(BURST_BYTES);

    typedef enum logic [1:0] {FREE, WRITING, FULL, READING} buf_state_t;

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_BUSY} w_state_t;

    function automatic logic frame_bytes_ok(input logic [31:0] bytes);
        return (bytes[BURST_LSB-1:0] == '0) && (bytes != '0);
    endfunction

endpackage

// File: rtl/dram_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and its writer / reader DMA.
//   master : scheduler side (issues write commands, offers complete frames)
//   slave  : DramWriter + reader DMA side
//
// Handshake rules: a transfer happens on a rising clock edge where valid and
// ready are both 1. Once valid is raised, valid and its payload (BUF_ADDR,
// FRAME_BYTES) stay stable until that transfer; ready may toggle freely.
// wr_frame_done / rd_frame_done are single-cycle pulses with no handshake.
interface dram_frame_scheduler_if #(
    parameter int ADDR_W = 32
);
    logic              wr_frame_valid;
    logic              wr_frame_ready;
    logic [ADDR_W-1:0] wr_BUF_ADDR;
    logic [31:0]       wr_FRAME_BYTES;
    logic              wr_frame_done;

    logic              rd_frame_valid;
    logic              rd_frame_ready;
    logic [ADDR_W-1:0] rd_BUF_ADDR;
    logic              rd_frame_done;

    modport master (
        output wr_frame_valid, wr_BUF_ADDR, wr_FRAME_BYTES,
        input  wr_frame_ready, wr_frame_done,
        output rd_frame_valid, rd_BUF_ADDR,
        input  rd_frame_ready, rd_frame_done
    );

    modport slave (
        input  wr_frame_valid, wr_BUF_ADDR, wr_FRAME_BYTES,
        output wr_frame_ready, wr_frame_done,
        input  rd_frame_valid, rd_BUF_ADDR,
        output rd_frame_ready, rd_frame_done
    );
endinterface

// File: rtl/dram_frame_scheduler_rr_free_picker.sv
// Combinational round-robin search for the first FREE buffer.
//   st    : per-buffer state vector
//   start : index where the search begins (wraps modulo NBUF)
//   found : some buffer is FREE
//   idx   : first FREE index at or after start
module rr_free_picker
    import dram_sched_pkg::*;
#(
    parameter  int NBUF  = 3,
    localparam int IDX_W = $clog2(NBUF)
) (
    input  buf_state_t       st [NBUF],
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NBUF; k++) begin
            j = (int'(start) + k) % NBUF;
            if (!found && st[j] == FREE) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/dram_frame_scheduler.sv
// Frame-buffer manager for the DRAM write path. Owns NBUF buffers at
// cfg_base_addr + i*cfg_stride, hands the writer one free buffer per frame
// and offers the newest complete frame to a single reader, never letting the
// writer touch the buffer the reader holds.
//   fclk, rst       : clock, synchronous active-high reset
//   cfg_*           : enable, buffer base/stride, frame size (sampled at issue)
//   bus (master)    : writer command + reader offer handshakes
//   frames_written  : completed frame writes (wraps)
//   frames_dropped  : complete frames overwritten before being read (wraps)
//   cfg_error       : sticky, invalid frame size seen at issue time
//   wstate          : writer FSM state (debug)
module dram_frame_scheduler
    import dram_sched_pkg::*;
#(
    parameter int NBUF   = 3,
    parameter int ADDR_W = 32
) (
    input  logic              fclk,
    input  logic              rst,
    input  logic              cfg_enable,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic [31:0]       cfg_frame_bytes,
    dram_frame_scheduler_if.master bus,
    output logic [31:0]       frames_written,
    output logic [31:0]       frames_dropped,
    output logic              cfg_error,
    output w_state_t          wstate
);

    localparam int IDX_W = $clog2(NBUF);

    buf_state_t       buf_st  [NBUF];
    buf_state_t       buf_nxt [NBUF];
    w_state_t         wstate_nxt;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] pick_start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             issue_try, pick_ev, cfg_bad;
    logic             wr_done_ev, claim_ev, drop_ev;
    logic             full_any, full_nxt, read_nxt;

    // Search starts just after the most recently issued buffer.
    assign pick_start = (last_idx == IDX_W'(NBUF - 1)) ? '0 : last_idx + 1'b1;

    rr_free_picker #(.NBUF(NBUF)) u_picker (
        .st    (buf_st),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Events, all decided on pre-edge state.
    always_comb begin
        issue_try  = (wstate == W_IDLE) && cfg_enable && pick_found;
        pick_ev    = issue_try && frame_bytes_ok(cfg_frame_bytes);
        cfg_bad    = issue_try && !frame_bytes_ok(cfg_frame_bytes);
        wr_done_ev = (wstate == W_BUSY) && bus.wr_frame_done;
        claim_ev   = bus.rd_frame_valid && bus.rd_frame_ready;
        full_any   = 1'b0;
        for (int i = 0; i < NBUF; i++) begin
            if (buf_st[i] == FULL) full_any = 1'b1;
        end
        // A FULL buffer claimed in the same cycle survives as READING.
        drop_ev = wr_done_ev && full_any && !claim_ev;
    end

    // Per-buffer next state. A buffer released by the reader this cycle is
    // still READING in buf_st, so the picker cannot hand it out until later.
    always_comb begin
        full_nxt = 1'b0;
        read_nxt = 1'b0;
        for (int i = 0; i < NBUF; i++) begin
            buf_nxt[i] = buf_st[i];
            case (buf_st[i])
                FREE:    if (pick_ev && pick_idx == IDX_W'(i)) buf_nxt[i] = WRITING;
                WRITING: if (wr_done_ev) buf_nxt[i] = FULL;
                FULL:    if (claim_ev) buf_nxt[i] = READING;
                         else if (wr_done_ev) buf_nxt[i] = FREE;
                READING: if (bus.rd_frame_done) buf_nxt[i] = FREE;
                default: buf_nxt[i] = FREE;
            endcase
            if (buf_nxt[i] == FULL)    full_nxt = 1'b1;
            if (buf_nxt[i] == READING) read_nxt = 1'b1;
        end
    end

    // Writer FSM: state register.
    always_ff @(posedge fclk) begin
        if (rst) wstate <= W_IDLE;
        else     wstate <= wstate_nxt;
    end

    // Writer FSM: next state.
    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_IDLE:  if (pick_ev) wstate_nxt = W_ISSUE;
            W_ISSUE: if (bus.wr_frame_ready) wstate_nxt = W_BUSY;
            W_BUSY:  if (bus.wr_frame_done) wstate_nxt = W_IDLE;
            default: wstate_nxt = W_IDLE;
        endcase
    end

    // Writer FSM: outputs.
    always_comb begin
        bus.wr_frame_valid = (wstate == W_ISSUE);
    end

    // Buffer states, command payload, reader offer, counters.
    always_ff @(posedge fclk) begin
        if (rst) begin
            for (int i = 0; i < NBUF; i++) buf_st[i] <= FREE;
            last_idx           <= IDX_W'(NBUF - 1);
            bus.wr_BUF_ADDR    <= '0;
            bus.wr_FRAME_BYTES <= '0;
            bus.rd_frame_valid <= 1'b0;
            bus.rd_BUF_ADDR    <= '0;
            frames_written     <= '0;
            frames_dropped     <= '0;
            cfg_error          <= 1'b0;
        end else begin
            for (int i = 0; i < NBUF; i++) buf_st[i] <= buf_nxt[i];
            if (pick_ev) begin
                last_idx           <= pick_idx;
                bus.wr_BUF_ADDR    <= cfg_base_addr + ADDR_W'(pick_idx) * cfg_stride;
                bus.wr_FRAME_BYTES <= cfg_frame_bytes;
            end
            // rd_BUF_ADDR always tracks the FULL buffer; only the frame just
            // written can become FULL, so it is loaded on completion.
            if (wr_done_ev) bus.rd_BUF_ADDR <= bus.wr_BUF_ADDR;
            bus.rd_frame_valid <= full_nxt && !read_nxt;
            if (wr_done_ev) frames_written <= frames_written + 32'd1;
            if (drop_ev)    frames_dropped <= frames_dropped + 32'd1;
            if (cfg_bad)    cfg_error      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dram_frame_scheduler.sv
// Directed bench for dram_frame_scheduler: an NBUF=3 instance (a_*) for
// rotation, drop, reader hold, simultaneous events, cfg error and reset, and
// an NBUF=2 instance (b_*) for the writer stall case.
module tb_dram_frame_scheduler;
    import dram_sched_pkg::*;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] STRIDE = 32'h0010_0000;
    localparam logic [31:0] BYTES  = 32'h0004_B000;

    // ---------------- clock / reset ----------------
    logic fclk = 1'b0;
    always #5 fclk = ~fclk;

    logic        rst_a, rst_b, enable_a, enable_b;
    logic [31:0] cfg_base, cfg_stride, cfg_bytes;
    logic [31:0] a_written, a_dropped, b_written, b_dropped;
    logic        a_cfg_error, b_cfg_error;
    w_state_t    a_wstate, b_wstate;

    dram_frame_scheduler_if #(.ADDR_W(32)) a_if ();
    dram_frame_scheduler_if #(.ADDR_W(32)) b_if ();

    dram_frame_scheduler #(.NBUF(3), .ADDR_W(32)) dut_a (
        .fclk(fclk), .rst(rst_a), .cfg_enable(enable_a),
        .cfg_base_addr(cfg_base), .cfg_stride(cfg_stride), .cfg_frame_bytes(cfg_bytes),
        .bus(a_if), .frames_written(a_written), .frames_dropped(a_dropped),
        .cfg_error(a_cfg_error), .wstate(a_wstate)
    );

    dram_frame_scheduler #(.NBUF(2), .ADDR_W(32)) dut_b (
        .fclk(fclk), .rst(rst_b), .cfg_enable(enable_b),
        .cfg_base_addr(cfg_base), .cfg_stride(cfg_stride), .cfg_frame_bytes(cfg_bytes),
        .bus(b_if), .frames_written(b_written), .frames_dropped(b_dropped),
        .cfg_error(b_cfg_error), .wstate(b_wstate)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_wr_a[$];
    logic [63:0] exp_wr_b[$];
    logic [31:0] exp_rd_a[$];
    logic [31:0] exp_rd_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] baddr(input int i);
        return BASE + 32'(i) * STRIDE;
    endfunction

    task automatic pop_wr(input string name, ref logic [63:0] q[$],
                          input logic [31:0] addr, input logic [31:0] bytes);
        logic [63:0] e;
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: unexpected command addr 0x%0h", name, addr);
        end else begin
            e = q.pop_front();
            check({name, "_addr"}, addr, e[31:0]);
            check({name, "_bytes"}, bytes, e[63:32]);
        end
    endtask

    task automatic pop_rd(input string name, ref logic [31:0] q[$], input logic [31:0] addr);
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: unexpected claim addr 0x%0h", name, addr);
        end else begin
            check(name, addr, q.pop_front());
        end
    endtask

    // Monitors: compare every accepted handshake against the queues.
    always @(negedge fclk) begin
        if (!rst_a && a_if.wr_frame_valid && a_if.wr_frame_ready)
            pop_wr("wr_cmd_a", exp_wr_a, a_if.wr_BUF_ADDR, a_if.wr_FRAME_BYTES);
        if (!rst_a && a_if.rd_frame_valid && a_if.rd_frame_ready)
            pop_rd("rd_claim_a", exp_rd_a, a_if.rd_BUF_ADDR);
        if (!rst_b && b_if.wr_frame_valid && b_if.wr_frame_ready)
            pop_wr("wr_cmd_b", exp_wr_b, b_if.wr_BUF_ADDR, b_if.wr_FRAME_BYTES);
        if (!rst_b && b_if.rd_frame_valid && b_if.rd_frame_ready)
            pop_rd("rd_claim_b", exp_rd_b, b_if.rd_BUF_ADDR);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic wait_busy_a(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge fclk);
            if (a_wstate == W_BUSY) break;
        end
        check(name, 32'(a_wstate), 32'(W_BUSY));
    endtask

    task automatic wait_busy_b(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge fclk);
            if (b_wstate == W_BUSY) break;
        end
        check(name, 32'(b_wstate), 32'(W_BUSY));
    endtask

    task automatic done_a();
        tick();
        a_if.wr_frame_done = 1'b1;
        tick();
        a_if.wr_frame_done = 1'b0;
    endtask

    task automatic done_b();
        tick();
        b_if.wr_frame_done = 1'b1;
        tick();
        b_if.wr_frame_done = 1'b0;
    endtask

    task automatic push_a(input int buf_idx);
        exp_wr_a.push_back({BYTES, baddr(buf_idx)});
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_wr_valid"}, 32'(a_if.wr_frame_valid), 32'd0);
        check({tag, "_rd_valid"}, 32'(a_if.rd_frame_valid), 32'd0);
        check({tag, "_wr_addr"},  a_if.wr_BUF_ADDR, 32'd0);
        check({tag, "_wr_bytes"}, a_if.wr_FRAME_BYTES, 32'd0);
        check({tag, "_rd_addr"},  a_if.rd_BUF_ADDR, 32'd0);
        check({tag, "_written"},  a_written, 32'd0);
        check({tag, "_dropped"},  a_dropped, 32'd0);
        check({tag, "_cfg_err"},  32'(a_cfg_error), 32'd0);
        check({tag, "_wstate"},   32'(a_wstate), 32'(W_IDLE));
    endtask

    // ---------------- stimulus ----------------
    int seq_a[11] = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2, 0};
    int stall_cnt;
    logic resumed;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; enable_a = 1'b0; enable_b = 1'b0;
        cfg_base = BASE; cfg_stride = STRIDE; cfg_bytes = BYTES;
        a_if.wr_frame_ready = 1'b0; a_if.wr_frame_done = 1'b0;
        a_if.rd_frame_ready = 1'b0; a_if.rd_frame_done = 1'b0;
        b_if.wr_frame_ready = 1'b0; b_if.wr_frame_done = 1'b0;
        b_if.rd_frame_ready = 1'b0; b_if.rd_frame_done = 1'b0;
        repeat (3) tick();
        rst_a = 1'b0;
        check_reset_a("reset");

        // Rotation 0,1,2,0,1 with no reader; frame 6 goes to buffer 2.
        for (int i = 0; i < 6; i++) push_a(seq_a[i]);
        a_if.wr_frame_ready = 1'b1;
        enable_a = 1'b1;
        repeat (5) begin
            wait_busy_a("busy_rot");
            done_a();
        end
        check("rot_written", a_written, 32'd5);
        check("rot_dropped", a_dropped, 32'd4);
        check("rot_rd_valid", 32'(a_if.rd_frame_valid), 32'd1);
        check("rot_rd_addr", a_if.rd_BUF_ADDR, baddr(1));

        // Claim and completion in the same cycle: reader gets the older frame.
        wait_busy_a("busy_f6");
        exp_rd_a.push_back(baddr(1));
        tick();
        a_if.rd_frame_ready = 1'b1;
        a_if.wr_frame_done  = 1'b1;
        tick();
        a_if.rd_frame_ready = 1'b0;
        a_if.wr_frame_done  = 1'b0;
        check("same_written", a_written, 32'd6);
        check("same_dropped", a_dropped, 32'd4);
        check("same_rd_valid", 32'(a_if.rd_frame_valid), 32'd0);

        // Reader holds buffer 1: writer alternates between buffers 0 and 2.
        for (int i = 6; i < 11; i++) push_a(seq_a[i]);
        repeat (4) begin
            wait_busy_a("busy_hold");
            done_a();
        end
        check("hold_written", a_written, 32'd10);
        check("hold_dropped", a_dropped, 32'd8);

        // Release buffer 1 while frame 11 is written; it is reused for frame 12.
        wait_busy_a("busy_f11");
        tick();
        a_if.rd_frame_done = 1'b1;
        tick();
        a_if.rd_frame_done = 1'b0;
        check("rel_rd_valid", 32'(a_if.rd_frame_valid), 32'd1);
        check("rel_rd_addr", a_if.rd_BUF_ADDR, baddr(2));
        push_a(1);
        done_a();
        check("rel_written", a_written, 32'd11);
        check("rel_dropped", a_dropped, 32'd9);

        // Invalid frame size set mid-frame: blocks only the next issue.
        wait_busy_a("busy_f12");
        cfg_bytes = 32'h0004_B010;
        done_a();
        repeat (5) tick();
        check("cfg_err_set", 32'(a_cfg_error), 32'd1);
        check("cfg_err_no_issue", 32'(a_if.wr_frame_valid), 32'd0);
        check("cfg_err_wstate", 32'(a_wstate), 32'(W_IDLE));
        check("cfg_err_written", a_written, 32'd12);

        // Valid size again: frame 13 to buffer 2, reader claims buffer 1.
        cfg_bytes = BYTES;
        push_a(2);
        wait_busy_a("busy_f13");
        exp_rd_a.push_back(baddr(1));
        tick();
        a_if.rd_frame_ready = 1'b1;
        tick();
        a_if.rd_frame_ready = 1'b0;
        check("pre_rst_cfg_err", 32'(a_cfg_error), 32'd1);
        check("pre_rst_wstate", 32'(a_wstate), 32'(W_BUSY));

        // Reset while writing and reading; first issue afterwards is buffer 0.
        rst_a = 1'b1;
        tick();
        check_reset_a("midrst");
        rst_a = 1'b0;
        push_a(0);
        wait_busy_a("busy_after_rst");
        check("a_wr_q_empty", 32'(exp_wr_a.size()), 32'd0);
        check("a_rd_q_empty", 32'(exp_rd_a.size()), 32'd0);

        // NBUF=2: one READING + one FULL stalls the writer without a drop.
        rst_b = 1'b0;
        b_if.wr_frame_ready = 1'b1;
        exp_wr_b.push_back({BYTES, baddr(0)});
        exp_wr_b.push_back({BYTES, baddr(1)});
        enable_b = 1'b1;
        wait_busy_b("b_busy0");
        done_b();
        wait_busy_b("b_busy1");
        exp_rd_b.push_back(baddr(0));
        tick();
        b_if.rd_frame_ready = 1'b1;
        tick();
        b_if.rd_frame_ready = 1'b0;
        done_b();
        check("b_written", b_written, 32'd2);
        stall_cnt = 0;
        repeat (10) begin
            @(negedge fclk);
            if (b_if.wr_frame_valid) stall_cnt++;
        end
        check("b_stall_no_issue", 32'(stall_cnt), 32'd0);
        check("b_stall_dropped", b_dropped, 32'd0);
        exp_wr_b.push_back({BYTES, baddr(0)});
        tick();
        b_if.rd_frame_done = 1'b1;
        tick();
        b_if.rd_frame_done = 1'b0;
        resumed = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge fclk);
            if (b_if.wr_frame_valid) begin
                resumed = 1'b1;
                break;
            end
        end
        check("b_resume_2cyc", 32'(resumed), 32'd1);
        wait_busy_b("b_busy2");
        check("b_wr_q_empty", 32'(exp_wr_b.size()), 32'd0);
        check("b_rd_q_empty", 32'(exp_rd_b.size()), 32'd0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
